// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit.
//   Issues word-aligned read requests to instruction memory and registers each
//   returned word for the control decoder. It holds that word while decode
//   stalls, redirects on branch_taken, and counts delivered instructions.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | just out of reset; no request issued yet
// FETCH   | request to pc outstanding, waiting for imem_ack
// DELIVER | instrWord valid, waiting for decode to accept (stall = 0)
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   imem_req/addr     read request and word address (out)
//   imem_ack/rdata    memory response and data (in)
//   stall             decode cannot accept this cycle (in)
//   branch_taken/target  one-cycle redirect (in)
//   instrWord, instr_valid, pc_plus4  registered instruction to decoder (out)
//   illegal_op        opcode of the valid instruction is unsupported (out)
//   fetch_count       saturating count of delivered instructions (out)
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instrWord,
  output logic        instr_valid,
  output logic [31:0] pc_plus4,
  output logic        illegal_op,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, DELIVER} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;       // redirect target parked while a flushed request completes
  logic        flush_q;
  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;
  logic [15:0] count_q;

  logic [31:0] br_tgt;
  logic [31:0] pc_inc;
  logic [5:0]  opcode;
  logic        unused_tgt_bits;

  assign br_tgt          = {branch_target[31:2], 2'b00};
  assign pc_inc          = pc_q + 32'd4;
  assign unused_tgt_bits = ^branch_target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= {RESET_PC[31:2], 2'b00};
      tgt_q      <= 32'h0;
      flush_q    <= 1'b0;
      instr_q    <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
      count_q    <= 16'h0;
    end else begin
      case (state_q)
        IDLE: begin
          // A response seen here belongs to a request abandoned by reset.
          if (branch_taken) pc_q <= br_tgt;
          state_q <= FETCH;
        end
        FETCH: begin
          if (branch_taken) begin
            if (imem_ack) begin
              pc_q    <= br_tgt;
              flush_q <= 1'b0;
            end else begin
              // Address must stay stable until the outstanding ack arrives.
              flush_q <= 1'b1;
              tgt_q   <= br_tgt;
            end
          end else if (imem_ack) begin
            if (flush_q) begin
              pc_q    <= tgt_q;
              flush_q <= 1'b0;
            end else begin
              instr_q    <= imem_rdata;
              pc_plus4_q <= pc_inc;
              pc_q       <= pc_inc;
              valid_q    <= 1'b1;
              state_q    <= DELIVER;
            end
          end
        end
        DELIVER: begin
          if (branch_taken) begin
            pc_q    <= br_tgt;
            valid_q <= 1'b0;
            state_q <= FETCH;
          end else if (!stall) begin
            valid_q <= 1'b0;
            if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
            state_q <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign opcode = instr_q[31:26];

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instrWord   = instr_q;
  assign instr_valid = valid_q;
  assign pc_plus4    = pc_plus4_q;
  assign fetch_count = count_q;
  assign illegal_op  = valid_q && !((opcode == 6'h00) || (opcode == 6'h23) ||
                                    (opcode == 6'h2B) || (opcode == 6'h04));

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port imem_req  output  1  instruction memory read request.
REQ-005 SHALL have port imem_addr  output  32  word address of the request (bits [1:0] always 0).
REQ-006 SHALL have port imem_ack  input  1  memory response valid; imem_rdata is valid in the same cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port stall  input  1  downstream decode cannot accept the instruction this cycle.
REQ-009 SHALL have port branch_taken  input  1  redirect request, one cycle wide.
REQ-010 SHALL have port branch_target  input  32  redirect address; bits [1:0] ignored and forced to 0.
REQ-011 SHALL have port instrWord  output  32  registered instruction to the control decoder.
REQ-012 SHALL have port instr_valid  output  1  instrWord holds an undelivered instruction.
REQ-013 SHALL have port pc_plus4  output  32  registered address of instrWord plus 4.
REQ-014 SHALL have port illegal_op  output  1  instr_valid and instrWord[31:26] not in {6'h00, 6'h23, 6'h2B, 6'h04}.
REQ-015 SHALL have port fetch_count  output  16  count of delivered instructions, saturating.

Function
REQ-016 SHALL implement states IDLE, FETCH, DELIVER; imem_req = (state == FETCH); imem_addr = pc.
REQ-017 SHALL move IDLE -> FETCH on the first clock edge after rst_n deasserts.
REQ-018 SHALL hold imem_addr stable while imem_req = 1 and imem_ack = 0; one outstanding request only.
REQ-019 In FETCH with imem_ack = 1 and no pending flush: SHALL capture instrWord <= imem_rdata, pc_plus4 <= pc + 4, pc <= pc + 4, instr_valid <= 1, state -> DELIVER.
REQ-020 Response latency SHALL be one cycle: instr_valid rises on the edge that samples imem_ack.
REQ-021 An instruction is consumed in any cycle with instr_valid = 1 and stall = 0; on that edge: instr_valid <= 0, fetch_count increments, state -> FETCH.
REQ-022 While in DELIVER with stall = 1: instrWord, pc_plus4, instr_valid SHALL hold unchanged.
REQ-023 branch_taken SHALL have priority over stall and imem_ack; on that edge pc <= {branch_target[31:2], 2'b00}.
REQ-024 branch_taken in DELIVER: instr_valid <= 0, no fetch_count increment, state -> FETCH.
REQ-025 branch_taken in FETCH with imem_ack = 1 in the same cycle: response discarded, state stays FETCH, new request to target next cycle.
REQ-026 branch_taken in FETCH with imem_ack = 0: SHALL set flush flag; imem_addr stays at the old address until ack; that response is discarded, flush clears, next request uses target.
REQ-027 branch_taken in IDLE: SHALL update pc only; first fetch goes to target.
REQ-028 pc arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-029 fetch_count SHALL saturate at 16'hFFFF.
REQ-030 illegal_op SHALL be combinational from instrWord and instr_valid; 0 when instr_valid = 0.

Reset
REQ-031 On rst_n = 0, immediately and independent of clk: state = IDLE, pc = RESET_PC, instrWord = 0, pc_plus4 = 0, instr_valid = 0, flush = 0, fetch_count = 0; hence imem_req = 0, illegal_op = 0.
REQ-032 Reset asserted mid-request SHALL abandon the request; an imem_ack arriving after reset release while in IDLE SHALL be ignored.

Verification
REQ-033 Reset release, memory acks every request next cycle, stall = 0 -> imem_addr sequence 0x0, 0x4, 0x8; instrWord equals rdata; fetch_count = 3 after third consume.
REQ-034 Instruction 32'h8C01_0004 delivered, stall = 1 for 3 cycles -> instrWord, pc_plus4 = 0x4 held, instr_valid = 1 throughout; count increments once after stall drops.
REQ-035 branch_taken with target 0x0000_0103 while request to 0x8 pending (ack 2 cycles later) -> addr stays 0x8 until ack, data discarded, next imem_addr = 0x100, no instr_valid for 0x8.
REQ-036 RESET_PC = 32'hFFFF_FFFC, one fetch -> pc_plus4 = 0x0, next imem_addr = 0x0.
REQ-037 rdata = 32'h0800_0000 (opcode 6'h02) -> illegal_op = 1 with instr_valid; rdata = 32'h1000_0000 -> illegal_op = 0.
REQ-038 rst_n pulsed low mid-DELIVER between edges -> instr_valid = 0, imem_req = 0 immediately; first post-reset request to RESET_PC.
